// File: rtl/simd_sequencer.sv
// Instruction sequencer for an external SIMD ALU. It fetches 16-bit instructions,
// issues operands from a 16-entry register file, waits ALU_LATENCY cycles and writes back.
module simd_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int PC_WIDTH     = 8,
    parameter int ALU_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic [15:0]             imem_data,
    input  logic                    host_we,
    input  logic [3:0]              host_waddr,
    input  logic [DATA_WIDTH-1:0]   host_wdata,
    input  logic [3:0]              host_raddr,
    output logic [DATA_WIDTH-1:0]   host_rdata,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [OPCODE_WIDTH-1:0] opcode_out,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOOP          = 4'd0;
    localparam logic [3:0] OP_STORE_TEMP_S1 = 4'd5;
    localparam logic [3:0] OP_STORE_TEMP_S2 = 4'd6;
    localparam logic [3:0] OP_STORE_RESULT  = 4'd7;
    localparam logic [3:0] OP_STOP          = 4'd8;
    localparam logic [3:0] LAT              = 4'(ALU_LATENCY);

    state_t                  state_reg, state_next;
    logic [PC_WIDTH-1:0]     pc_reg, pc_next;
    logic [DATA_WIDTH-1:0]   alu_a_reg, alu_a_next;
    logic [DATA_WIDTH-1:0]   alu_b_reg, alu_b_next;
    logic [OPCODE_WIDTH-1:0] opcode_out_reg, opcode_out_next;
    logic [3:0]              op_reg, op_next;
    logic [3:0]              rd_reg, rd_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic                    done_reg, done_next;
    logic                    err_reg, err_next;

    logic [DATA_WIDTH-1:0]   rf [16];
    logic [15:0]             rf_we;
    logic [DATA_WIDTH-1:0]   rf_wdata;
    logic                    wb_we;
    logic                    host_ok;

    logic [3:0] dec_op, dec_ra, dec_rb, dec_rd;
    logic       dec_alu_class;

    assign dec_op        = imem_data[15:12];
    assign dec_ra        = imem_data[11:8];
    assign dec_rb        = imem_data[7:4];
    assign dec_rd        = imem_data[3:0];
    assign dec_alu_class = (dec_op != OP_NOOP) && (dec_op <= OP_STORE_RESULT);

    assign busy = (state_reg == FETCH) || (state_reg == DECODE) ||
                  (state_reg == EXEC)  || (state_reg == WB);

    // Opcode is kept internally because opcode_out is already zero during WB.
    assign wb_we   = (state_reg == WB) && (op_reg != OP_STORE_TEMP_S1) &&
                     (op_reg != OP_STORE_TEMP_S2);
    assign host_ok = host_we && !busy;
    assign rf_wdata = wb_we ? alu_result : host_wdata;

    for (genvar gi = 0; gi < 16; gi++) begin : g_rf_we
        assign rf_we[gi] = (wb_we   && (rd_reg     == 4'(gi))) ||
                           (host_ok && (host_waddr == 4'(gi)));
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        alu_a_next      = alu_a_reg;
        alu_b_next      = alu_b_reg;
        opcode_out_next = opcode_out_reg;
        op_next         = op_reg;
        rd_next         = rd_reg;
        cnt_next        = cnt_reg;
        done_next       = done_reg;
        err_next        = err_reg;

        case (state_reg)
            IDLE, HALT: begin
                opcode_out_next = '0;
                if (start) begin
                    pc_next    = '0;
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = DECODE;
            end
            DECODE: begin
                alu_a_next = rf[dec_ra];
                alu_b_next = rf[dec_rb];
                op_next    = dec_op;
                rd_next    = dec_rd;
                if (dec_alu_class) begin
                    opcode_out_next = OPCODE_WIDTH'(dec_op);
                    cnt_next        = LAT;
                    state_next      = EXEC;
                end else if (dec_op == OP_STOP) begin
                    // STOP is visible on opcode_out for the first HALT cycle only.
                    opcode_out_next = OPCODE_WIDTH'(OP_STOP);
                    done_next       = 1'b1;
                    state_next      = HALT;
                end else begin
                    opcode_out_next = '0;
                    pc_next         = pc_reg + 1'b1;
                    state_next      = FETCH;
                    if (dec_op > OP_STOP) begin
                        err_next = 1'b1;
                    end
                end
            end
            EXEC: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= 4'd1) begin
                    cnt_next        = '0;
                    opcode_out_next = '0;
                    state_next      = WB;
                end
            end
            WB: begin
                pc_next    = pc_reg + 1'b1;
                state_next = FETCH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            opcode_out_reg <= '0;
            op_reg         <= '0;
            rd_reg         <= '0;
            cnt_reg        <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                rf[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
            opcode_out_reg <= opcode_out_next;
            op_reg         <= op_next;
            rd_reg         <= rd_next;
            cnt_reg        <= cnt_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            for (int i = 0; i < 16; i++) begin
                if (rf_we[i]) begin
                    rf[i] <= rf_wdata;
                end
            end
        end
    end

    assign imem_addr  = pc_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign opcode_out = opcode_out_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign host_rdata = rf[host_raddr];

endmodule

// File: tb/tb_simd_sequencer.sv
// Directed bench: instance A (latency 1, 8-bit pc) runs the vector table and
// multi-cycle sequences; instance B (latency 3, 2-bit pc) covers mid-EXEC reset and pc wrap.
module tb_simd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, host_we_a, busy_a, done_a, err_a;
    logic [7:0]  imem_addr_a;
    logic [15:0] imem_data_a;
    logic [3:0]  host_waddr_a, host_raddr_a, opcode_out_a;
    logic [31:0] host_wdata_a, host_rdata_a, alu_a_a, alu_b_a, alu_result_a;

    logic        rst_b, start_b, host_we_b, busy_b, done_b, err_b;
    logic [1:0]  imem_addr_b;
    logic [15:0] imem_data_b;
    logic [3:0]  host_waddr_b, host_raddr_b, opcode_out_b;
    logic [31:0] host_wdata_b, host_rdata_b, alu_a_b, alu_b_b, alu_result_b;

    simd_sequencer #(.OPCODE_WIDTH(4), .DATA_WIDTH(32), .PC_WIDTH(8), .ALU_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a),
        .imem_addr(imem_addr_a), .imem_data(imem_data_a),
        .host_we(host_we_a), .host_waddr(host_waddr_a), .host_wdata(host_wdata_a),
        .host_raddr(host_raddr_a), .host_rdata(host_rdata_a),
        .alu_a(alu_a_a), .alu_b(alu_b_a), .opcode_out(opcode_out_a),
        .alu_result(alu_result_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    simd_sequencer #(.OPCODE_WIDTH(4), .DATA_WIDTH(32), .PC_WIDTH(2), .ALU_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b),
        .imem_addr(imem_addr_b), .imem_data(imem_data_b),
        .host_we(host_we_b), .host_waddr(host_waddr_b), .host_wdata(host_wdata_b),
        .host_raddr(host_raddr_b), .host_rdata(host_rdata_b),
        .alu_a(alu_a_b), .alu_b(alu_b_b), .opcode_out(opcode_out_b),
        .alu_result(alu_result_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    // Instruction memories with one-cycle read latency
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [4];
    always @(posedge clk) imem_data_a <= mem_a[imem_addr_a];
    always @(posedge clk) imem_data_b <= mem_b[imem_addr_b];

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1, 4'd5, 4'd6, 4'd7: alu_f = a + b;
            4'd2:                   alu_f = a - b;
            4'd3, 4'd4:             alu_f = a * b;
            default:                alu_f = 32'h0;
        endcase
    endfunction

    // ALU stubs: result valid ALU_LATENCY cycles after operands appear
    logic [31:0] pipe_b [3];
    always @(posedge clk) alu_result_a <= alu_f(opcode_out_a, alu_a_a, alu_b_a);
    always @(posedge clk) begin
        pipe_b[0] <= alu_f(opcode_out_b, alu_a_b, alu_b_b);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign alu_result_b = pipe_b[2];

    int checks = 0;
    int errors = 0;
    logic [3:0] ops_q [$];
    logic [3:0] last_op;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit b);
        if (b) rst_b = 1'b1; else rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic host_wr(input bit b, input logic [3:0] addr, input logic [31:0] data);
        if (b) begin host_we_b = 1'b1; host_waddr_b = addr; host_wdata_b = data; end
        else   begin host_we_a = 1'b1; host_waddr_a = addr; host_wdata_a = data; end
        tick();
        host_we_a = 1'b0;
        host_we_b = 1'b0;
    endtask

    task automatic host_rd(input bit b, input logic [3:0] addr, output logic [31:0] data);
        if (b) host_raddr_b = addr; else host_raddr_a = addr;
        #1;
        data = b ? host_rdata_b : host_rdata_a;
    endtask

    task automatic pulse_start(input bit b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit b, output int n);
        logic [3:0] op;
        n = 0;
        while (1) begin
            tick();
            n++;
            op = b ? opcode_out_b : opcode_out_a;
            if (op !== last_op) begin
                ops_q.push_back(op);
                last_op = op;
            end
            if ((b ? done_b : done_a) === 1'b1) break;
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL wait_done: done still 0 after %0d cycles, required 1", n);
                break;
            end
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  reg_idx;
        logic [31:0] exp_val;
        logic        exp_err;
        int          exp_cyc;
        string       name;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int          n;
        logic [31:0] d;
        logic [23:0] packed_ops;
        bit          stop_loaded, saw3, wrapped;

        vecs[0]  = '{16'h1123, 4'd3, 32'h15, 1'b0, 6, "ADD r3"};
        vecs[1]  = '{16'h2124, 4'd4, 32'h0B, 1'b0, 6, "SUB r4"};
        vecs[2]  = '{16'h3125, 4'd5, 32'h50, 1'b0, 6, "MUL r5"};
        vecs[3]  = '{16'h4126, 4'd6, 32'h50, 1'b0, 6, "DOTP r6"};
        vecs[4]  = '{16'h7127, 4'd7, 32'h15, 1'b0, 6, "STORE_RESULT r7"};
        vecs[5]  = '{16'h5120, 4'd0, 32'h00, 1'b0, 6, "STORE_TEMP_S1 r0"};
        vecs[6]  = '{16'h6125, 4'd5, 32'h00, 1'b0, 6, "STORE_TEMP_S2 r5"};
        vecs[7]  = '{16'h1121, 4'd1, 32'h15, 1'b0, 6, "ADD rd=ra"};
        vecs[8]  = '{16'h0123, 4'd3, 32'h00, 1'b0, 4, "NOOP"};
        vecs[9]  = '{16'hA123, 4'd3, 32'h00, 1'b1, 4, "ILLEGAL A"};
        vecs[10] = '{16'hF121, 4'd1, 32'h10, 1'b1, 4, "ILLEGAL F"};

        rst_a = 1'b1; start_a = 1'b0; host_we_a = 1'b0; host_waddr_a = '0; host_wdata_a = '0; host_raddr_a = '0;
        rst_b = 1'b1; start_b = 1'b0; host_we_b = 1'b0; host_waddr_b = '0; host_wdata_b = '0; host_raddr_b = '0;
        for (int i = 0; i < 256; i++) mem_a[i] = 16'h8000;
        for (int i = 0; i < 4; i++) mem_b[i] = 16'h0000;
        last_op = 4'd0;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        chk("reset imem_addr", imem_addr_a, 0);
        chk("reset alu_a", alu_a_a, 0);
        chk("reset alu_b", alu_b_a, 0);
        chk("reset opcode_out", opcode_out_a, 0);
        chk("reset busy", busy_a, 0);
        chk("reset done", done_a, 0);
        chk("reset err", err_a, 0);

        for (int i = 0; i < 11; i++) begin
            do_reset(0);
            host_wr(0, 4'd1, 32'h10);
            host_wr(0, 4'd2, 32'h5);
            mem_a[0] = vecs[i].instr;
            mem_a[1] = 16'h8000;
            ops_q.delete();
            last_op = 4'd0;
            pulse_start(0);
            wait_done(0, n);
            host_rd(0, vecs[i].reg_idx, d);
            $display("vec %0d %s: reg=0x%0h err=%0b cycles=%0d", i, vecs[i].name, d, err_a, n);
            chk({vecs[i].name, " value"}, d, vecs[i].exp_val);
            chk({vecs[i].name, " err"}, err_a, vecs[i].exp_err);
            chk({vecs[i].name, " cycles"}, n, vecs[i].exp_cyc);
            chk({vecs[i].name, " busy"}, busy_a, 0);
        end

        // SUB, STORE_TEMP_S1, STOP: opcode_out transitions
        do_reset(0);
        host_wr(0, 4'd1, 32'h10);
        host_wr(0, 4'd2, 32'h5);
        mem_a[0] = 16'h2124;
        mem_a[1] = 16'h5120;
        mem_a[2] = 16'h8000;
        ops_q.delete();
        last_op = 4'd0;
        pulse_start(0);
        wait_done(0, n);
        tick();
        if (opcode_out_a !== last_op) ops_q.push_back(opcode_out_a);
        packed_ops = '0;
        foreach (ops_q[k]) packed_ops = {packed_ops[19:0], ops_q[k]};
        $display("opseq: %0d changes packed=0x%06h", ops_q.size(), packed_ops);
        chk("opseq count", ops_q.size(), 6);
        chk("opseq values", packed_ops, 24'h205080);
        host_rd(0, 4'd4, d);
        chk("opseq r4", d, 32'hB);
        host_rd(0, 4'd0, d);
        chk("opseq r0", d, 32'h0);

        // start during EXEC ignored, then restart from HALT
        do_reset(0);
        host_wr(0, 4'd1, 32'h10);
        host_wr(0, 4'd2, 32'h5);
        mem_a[0] = 16'h1123;
        mem_a[1] = 16'h8000;
        pulse_start(0);
        tick();
        tick();
        chk("restart in exec opcode", opcode_out_a, 1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done(0, n);
        $display("restart: first run cycles=%0d", n + 3);
        chk("restart ignored cycles", n + 3, 6);
        host_rd(0, 4'd3, d);
        chk("restart first r3", d, 32'h15);
        host_wr(0, 4'd3, 32'h0);
        host_rd(0, 4'd3, d);
        chk("restart host write in halt", d, 32'h0);
        pulse_start(0);
        chk("restart busy", busy_a, 1);
        chk("restart done cleared", done_a, 0);
        host_wr(0, 4'd5, 32'h77);
        wait_done(0, n);
        host_rd(0, 4'd3, d);
        chk("restart second r3", d, 32'h15);
        host_rd(0, 4'd5, d);
        chk("restart host write while busy", d, 32'h0);
        chk("restart done", done_a, 1);

        // Instance B: latency 3 run, then reset mid-EXEC
        do_reset(1);
        host_wr(1, 4'd1, 32'h10);
        host_wr(1, 4'd2, 32'h5);
        mem_b[0] = 16'h1123;
        mem_b[1] = 16'h8000;
        pulse_start(1);
        wait_done(1, n);
        host_rd(1, 4'd3, d);
        $display("lat3 add: r3=0x%0h cycles=%0d", d, n);
        chk("lat3 cycles", n, 8);
        chk("lat3 r3", d, 32'h15);
        pulse_start(1);
        tick();
        tick();
        tick();
        chk("midexec opcode", opcode_out_b, 1);
        chk("midexec alu_a", alu_a_b, 32'h10);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("midexec rst imem_addr", imem_addr_b, 0);
        chk("midexec rst alu_a", alu_a_b, 0);
        chk("midexec rst alu_b", alu_b_b, 0);
        chk("midexec rst opcode", opcode_out_b, 0);
        chk("midexec rst busy", busy_b, 0);
        chk("midexec rst done", done_b, 0);
        host_rd(1, 4'd1, d);
        chk("midexec rst r1", d, 32'h0);
        host_rd(1, 4'd3, d);
        chk("midexec rst r3", d, 32'h0);

        // reset wins over start and host_we in the same cycle
        rst_b = 1'b1; start_b = 1'b1; host_we_b = 1'b1; host_waddr_b = 4'd2; host_wdata_b = 32'h99;
        tick();
        rst_b = 1'b0; start_b = 1'b0; host_we_b = 1'b0;
        chk("rst prio busy", busy_b, 0);
        host_rd(1, 4'd2, d);
        chk("rst prio host_we", d, 32'h0);
        tick();
        chk("rst prio busy later", busy_b, 0);

        // pc wrap on 2-bit pc: NOOPs, STOP placed at address 0 after first pass
        do_reset(1);
        for (int i = 0; i < 4; i++) mem_b[i] = 16'h0000;
        stop_loaded = 1'b0;
        saw3 = 1'b0;
        wrapped = 1'b0;
        pulse_start(1);
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (imem_addr_b == 2'd1 && !stop_loaded) begin
                mem_b[0] = 16'h8000;
                stop_loaded = 1'b1;
            end
            if (imem_addr_b == 2'd3) saw3 = 1'b1;
            if (saw3 && imem_addr_b == 2'd0) wrapped = 1'b1;
            if (done_b === 1'b1) break;
        end
        $display("wrap: wrapped=%0b done=%0b err=%0b cycles=%0d", wrapped, done_b, err_b, n);
        chk("wrap seen", wrapped, 1);
        chk("wrap done", done_b, 1);
        chk("wrap err", err_b, 0);
        chk("wrap cycles", n, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_sequencer.md
SIMD_SEQUENCER -- requirements
Module: simd_sequencer

Interface
REQ-001 Parameters SHALL be: OPCODE_WIDTH, default 4, opcode width; DATA_WIDTH, default 32, operand width; PC_WIDTH, default 8, instruction address width; ALU_LATENCY, default 1, cycles from operand issue to valid alu_result (legal range 1..15).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  single-cycle pulse, begins execution at PC 0.
REQ-006 imem_addr  out  PC_WIDTH  instruction address, registered; memory returns data one cycle later.
REQ-007 imem_data  in  16  instruction word: [15:12] opcode, [11:8] ra, [7:4] rb, [3:0] rd.
REQ-008 host_we, host_waddr, host_wdata  in  1/4/DATA_WIDTH  register-file preload port.
REQ-009 host_raddr  in  4, host_rdata  out  DATA_WIDTH  combinational register-file readback.
REQ-010 alu_a, alu_b  out  DATA_WIDTH  registered operands to ALU.
REQ-011 opcode_out  out  OPCODE_WIDTH  registered opcode to ALU.
REQ-012 alu_result  in  DATA_WIDTH  ALU output.
REQ-013 busy, done, err  out  1 each  running; halted on STOP; sticky illegal-opcode flag.

Function
REQ-014 Opcode map SHALL be: 0 NOOP, 1 ADD, 2 SUB, 3 MUL, 4 DOTP, 5 STORE_TEMP_S1, 6 STORE_TEMP_S2, 7 STORE_RESULT, 8 STOP, 9-15 illegal.
REQ-015 Internal register file SHALL be 16 x DATA_WIDTH.
REQ-016 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-017 IDLE/HALT: busy=0; start -> pc=0, done=0, err=0, FETCH.
REQ-018 FETCH: imem_addr=pc; -> DECODE next cycle.
REQ-019 DECODE: capture imem_data; alu_a=rf[ra], alu_b=rf[rb], opcode_out=opcode.
REQ-020 DECODE with opcode 1-7 -> EXEC, latency counter loaded with ALU_LATENCY.
REQ-021 DECODE with NOOP -> pc+1, FETCH; opcode_out=0.
REQ-022 DECODE with illegal opcode -> err=1, treated as NOOP, opcode_out=0.
REQ-023 DECODE with STOP -> opcode_out=8 for exactly one cycle, then HALT with done=1, busy=0, opcode_out=0.
REQ-024 EXEC: operands and opcode held stable; counter decrements; at zero -> WB.
REQ-025 WB: opcodes 1,2,3,4,7 write alu_result to rf[rd]; opcodes 5,6 write nothing; opcode_out=0; pc+1; -> FETCH.
REQ-026 An ALU-class instruction SHALL take 3+ALU_LATENCY cycles FETCH-to-FETCH; NOOP/illegal take 2.
REQ-027 pc SHALL wrap from 2^PC_WIDTH-1 to 0 without halting.
REQ-028 busy=1 in FETCH, DECODE, EXEC, WB.
REQ-029 start while busy SHALL be ignored; start in HALT restarts at pc 0.
REQ-030 host_we SHALL be honoured only when busy=0; ignored while busy.
REQ-031 rd=ra or rd=rb SHALL be legal; operands are those read in DECODE.

Reset
REQ-032 rst SHALL, from any state including mid-EXEC, force IDLE next cycle: pc=0, imem_addr=0, alu_a=0, alu_b=0, opcode_out=0, busy=0, done=0, err=0, all registers 0.
REQ-033 rst SHALL take priority over start and host_we in the same cycle.

Verification
REQ-034 Preload r1=0x10, r2=0x5; program {ADD r3,r1,r2; STOP}; ALU stub a+b, ALU_LATENCY=1 -> host_rdata(r3)=0x15, done=1, ADD FETCH-to-FETCH 4 cycles.
REQ-035 Program {SUB r4,r1,r2; STORE_TEMP_S1 r0,r1,r2; STOP} -> r4=0xB, r0 unchanged, opcode_out sequence 2,0,5,0,8 observed.
REQ-036 Program {0xA000; NOOP; STOP} -> err=1, no register changes, done=1.
REQ-037 Assert start again during EXEC of ADD -> ignored, program completes normally; start in HALT -> reruns, done cleared.
REQ-038 Assert rst during EXEC (ALU_LATENCY=3) -> next cycle all outputs 0, state IDLE, registers 0.
REQ-039 PC_WIDTH=2, memory {NOOP,NOOP,NOOP,NOOP} then STOP loaded at address 0 after first pass -> pc wraps 3->0, halts.
